// File: rtl/portal_host_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : portal_host_driver_if
// Description : Host command/response streams and muxed portal request and
//               indication ports seen by portal_host_driver.
// Revision    : 1.0  initial release
// ============================================================================
interface portal_host_driver_if;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;

    logic [1:0]  selectRequest;
    logic        EN_request;
    logic [31:0] requestEnqV;
    logic        RDY_requestEnq;

    logic [1:0]  selectIndication;
    logic        EN_indication;
    logic [31:0] indicationData;
    logic        indicationNotEmpty;
    logic        RDY_indication;
    logic [31:0] indIntrChannel;

    logic        err_badchan;

    modport master (
        input  cmd_valid, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output selectRequest, EN_request, requestEnqV,
        input  RDY_requestEnq,
        output selectIndication, EN_indication,
        input  indicationData, indicationNotEmpty, RDY_indication, indIntrChannel,
        output err_badchan
    );

    modport slave (
        output cmd_valid, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  selectRequest, EN_request, requestEnqV,
        output RDY_requestEnq,
        input  selectIndication, EN_indication,
        output indicationData, indicationNotEmpty, RDY_indication, indIntrChannel,
        input  err_badchan
    );
endinterface
`default_nettype wire

// File: rtl/portal_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : portal_host_driver
// Description : Replays framed host commands into portal request channels and
//               drains interrupting indication channels into framed responses.
// Revision    : 1.0  initial release
// ============================================================================
module portal_host_driver #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned NUM_IND   = 2,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    portal_host_driver_if.master bus
);
    localparam int unsigned c_PTR_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1,
        R_DROP = 2'd2
    } reqState_t;

    typedef enum logic [1:0] {
        I_IDLE  = 2'd0,
        I_DRAIN = 2'd1,
        I_HDR   = 2'd2,
        I_DATA  = 2'd3
    } indState_t;

    // ---------------- request path ----------------
    reqState_t   r_reqState, w_reqNext;
    logic [7:0]  r_reqCnt, w_reqCntNext;
    logic [1:0]  r_selReq, w_selReqNext;
    logic        w_reqBad;
    logic        w_reqFire;

    always_comb begin
        w_reqNext       = r_reqState;
        w_reqCntNext    = r_reqCnt;
        w_selReqNext    = r_selReq;
        w_reqBad        = 1'b0;
        w_reqFire       = 1'b0;
        bus.cmd_ready   = 1'b0;
        bus.EN_request  = 1'b0;
        bus.requestEnqV = '0;
        case (r_reqState)
            R_IDLE: begin
                // Held low during reset so no header is taken while clearing.
                bus.cmd_ready = !RST;
                if (bus.cmd_valid && !RST && bus.cmd_data[7:0] != 8'd0) begin
                    w_reqCntNext = bus.cmd_data[7:0];
                    if (32'(bus.cmd_data[31:30]) >= NUM_REQ) begin
                        w_reqBad  = 1'b1;
                        w_reqNext = R_DROP;
                    end else begin
                        w_selReqNext = bus.cmd_data[31:30];
                        w_reqNext    = R_DATA;
                    end
                end
            end
            R_DATA: begin
                w_reqFire       = bus.cmd_valid && bus.RDY_requestEnq;
                bus.EN_request  = w_reqFire;
                bus.cmd_ready   = w_reqFire;
                bus.requestEnqV = bus.cmd_data;
                if (w_reqFire) begin
                    w_reqCntNext = r_reqCnt - 8'd1;
                    if (r_reqCnt == 8'd1) w_reqNext = R_IDLE;
                end
            end
            R_DROP: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_reqCntNext = r_reqCnt - 8'd1;
                    if (r_reqCnt == 8'd1) w_reqNext = R_IDLE;
                end
            end
            default: w_reqNext = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_reqState <= R_IDLE;
            r_reqCnt   <= 8'd0;
            r_selReq   <= 2'd0;
        end else begin
            r_reqState <= w_reqNext;
            r_reqCnt   <= w_reqCntNext;
            r_selReq   <= w_selReqNext;
        end
    end

    assign bus.selectRequest = r_selReq;

    // ---------------- indication path ----------------
    indState_t   r_indState, w_indNext;
    logic [7:0]  r_cnt, w_cntNext;
    logic [7:0]  r_rdPtr, w_rdPtrNext;
    logic [1:0]  r_selInd, w_selIndNext;
    logic        w_indBad;
    logic        w_deq;
    logic [31:0] w_intrIdx;
    logic [31:0] r_buf [MAX_BURST];
    logic        r_err;

    assign w_intrIdx = bus.indIntrChannel - 32'd1;
    assign w_deq     = (r_indState == I_DRAIN) && bus.indicationNotEmpty &&
                       bus.RDY_indication && (32'(r_cnt) < MAX_BURST);

    always_comb begin
        w_indNext         = r_indState;
        w_cntNext         = r_cnt;
        w_rdPtrNext       = r_rdPtr;
        w_selIndNext      = r_selInd;
        w_indBad          = 1'b0;
        bus.EN_indication = w_deq;
        bus.rsp_valid     = 1'b0;
        bus.rsp_data      = '0;
        case (r_indState)
            I_IDLE: begin
                if (bus.indIntrChannel != 32'd0) begin
                    if (w_intrIdx >= NUM_IND) begin
                        w_indBad = 1'b1;
                    end else begin
                        w_selIndNext = w_intrIdx[1:0];
                        w_indNext    = I_DRAIN;
                    end
                end
            end
            I_DRAIN: begin
                if (w_deq) begin
                    w_cntNext = r_cnt + 8'd1;
                end else if (r_cnt == 8'd0) begin
                    w_indNext = I_IDLE;
                end else begin
                    w_indNext = I_HDR;
                end
            end
            I_HDR: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = {r_selInd, 22'b0, r_cnt};
                if (bus.rsp_ready) begin
                    w_rdPtrNext = 8'd0;
                    w_indNext   = I_DATA;
                end
            end
            I_DATA: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = r_buf[r_rdPtr[c_PTR_W-1:0]];
                if (bus.rsp_ready) begin
                    if (r_rdPtr == r_cnt - 8'd1) begin
                        w_cntNext   = 8'd0;
                        w_rdPtrNext = 8'd0;
                        w_indNext   = I_IDLE;
                    end else begin
                        w_rdPtrNext = r_rdPtr + 8'd1;
                    end
                end
            end
            default: w_indNext = I_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_indState <= I_IDLE;
            r_cnt      <= 8'd0;
            r_rdPtr    <= 8'd0;
            r_selInd   <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            r_indState <= w_indNext;
            r_cnt      <= w_cntNext;
            r_rdPtr    <= w_rdPtrNext;
            r_selInd   <= w_selIndNext;
            // One shared pulse even when both paths reject a channel together.
            r_err      <= w_reqBad || w_indBad;
        end
    end

    // Capture-only storage; validity is tracked by r_cnt, so no reset needed.
    always_ff @(posedge CLK) begin
        if (w_deq) r_buf[r_cnt[c_PTR_W-1:0]] <= bus.indicationData;
    end

    assign bus.selectIndication = r_selInd;
    assign bus.err_badchan      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_portal_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_portal_host_driver
// Description : Randomized scoreboard bench with a queue-based portal model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_portal_host_driver;
    localparam int NUM_REQ   = 3;
    localparam int NUM_IND   = 2;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 64;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    portal_host_driver_if bus ();

    portal_host_driver #(
        .NUM_REQ  (NUM_REQ),
        .NUM_IND  (NUM_IND),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int          nCompared   = 0;
    int          nMismatched = 0;
    int          expErr      = 0;
    int          errSeen     = 0;
    int          rspHs       = 0;
    logic [33:0] reqExp [$];
    logic [31:0] rspExp [$];
    logic [33:0] mReq;

    // Portal indication channels: simple circular queues.
    logic [31:0] indMem  [NUM_IND][DEPTH];
    int          indHead [NUM_IND] = '{default: 0};
    int          indTail [NUM_IND] = '{default: 0};
    logic        w_notEmpty;
    logic [31:0] w_data;
    logic        rspRand, rdyRand, rspRandom, rspForce;

    always_comb begin
        int s;
        s          = int'(bus.selectIndication);
        w_notEmpty = 1'b0;
        w_data     = '0;
        if (s < NUM_IND) begin
            w_notEmpty = indHead[s] != indTail[s];
            w_data     = indMem[s][indHead[s] % DEPTH];
        end
    end

    always @(posedge CLK) begin
        if (bus.EN_indication && int'(bus.selectIndication) < NUM_IND)
            indHead[int'(bus.selectIndication)] <= indHead[int'(bus.selectIndication)] + 1;
    end

    assign bus.indicationNotEmpty = w_notEmpty;
    assign bus.indicationData     = w_data;
    assign bus.RDY_indication     = 1'b1;
    assign bus.rsp_ready          = rspRandom ? rspRand : rspForce;
    assign bus.RDY_requestEnq     = rdyRand;

    initial begin
        rspRand = 1'b1;
        rdyRand = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            rspRand = ($urandom_range(0, 2) != 0);
            rdyRand = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        nCompared++;
        nMismatched++;
        $display("FAIL %s: actual %h with nothing outstanding", name, act);
    endtask

    // Monitor: samples on the falling edge, handshakes complete on the next rising edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (bus.EN_request) begin
                    if (reqExp.size() == 0) begin
                        unexpected("req_enqueue", {30'b0, bus.selectRequest, bus.requestEnqV});
                    end else begin
                        mReq = reqExp.pop_front();
                        check("req_chan", 64'(bus.selectRequest), 64'(mReq[33:32]));
                        check("req_word", 64'(bus.requestEnqV), 64'(mReq[31:0]));
                        check("req_cmd_ready", 64'(bus.cmd_ready), 64'd1);
                    end
                end
                if (bus.cmd_valid && !bus.RDY_requestEnq)
                    check("req_gated", 64'(bus.EN_request), 64'd0);
                if (bus.rsp_valid && bus.rsp_ready) begin
                    rspHs++;
                    if (rspExp.size() == 0) unexpected("rsp_word", 64'(bus.rsp_data));
                    else check("rsp_word", 64'(bus.rsp_data), 64'(rspExp.pop_front()));
                end
                if (bus.EN_indication)
                    check("ind_deq_nonempty", 64'(bus.indicationNotEmpty), 64'd1);
                if (bus.err_badchan) errSeen++;
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input bit noGap);
        bit acc;
        int t;
        if (!noGap && $urandom_range(0, 3) == 0) begin
            bus.cmd_valid = 1'b0;
            @(posedge CLK);
            #1;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = w;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 300) begin
            @(negedge CLK);
            acc = bus.cmd_ready;
            @(posedge CLK);
            #1;
            t++;
        end
        if (!acc) check("cmd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_msg(input logic [1:0] ch, input int n, input bit fixed);
        logic [31:0] w;
        logic [31:0] hdr;
        hdr = fixed ? {ch, 22'b0, 8'(n)} : {ch, 22'($urandom), 8'(n)};
        if (n > 0 && int'(ch) >= NUM_REQ) expErr++;
        send_word(hdr, 1'b0);
        for (int i = 0; i < n; i++) begin
            w = fixed ? 32'hAAAA_0001 + 32'(i) : $urandom;
            if (int'(ch) < NUM_REQ) reqExp.push_back({ch, w});
            send_word(w, 1'b0);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_req_done();
        int t;
        t = 0;
        while (reqExp.size() != 0 && t < 500) begin
            @(posedge CLK);
            t++;
        end
        check("req_drain_pending", 64'(reqExp.size()), 64'd0);
    endtask

    // Model: all words preloaded, so frames are MAX_BURST-sized chunks in order.
    task automatic ind_frame(input int ch, input int n, input bit fixed);
        logic [31:0] q [$];
        logic [31:0] w;
        int          k;
        int          t;
        for (int i = 0; i < n; i++) begin
            w = fixed ? 32'h11 * 32'(i + 1) : $urandom;
            indMem[ch][indTail[ch] % DEPTH] = w;
            indTail[ch]++;
            q.push_back(w);
        end
        while (q.size() != 0) begin
            k = (q.size() < MAX_BURST) ? q.size() : MAX_BURST;
            rspExp.push_back({2'(ch), 22'b0, 8'(k)});
            for (int i = 0; i < k; i++) rspExp.push_back(q.pop_front());
        end
        bus.indIntrChannel = 32'(ch + 1);
        t = 0;
        while (rspExp.size() != 0 && t < 2000) begin
            @(posedge CLK);
            t++;
        end
        #1;
        bus.indIntrChannel = 32'd0;
        check("ind_rsp_pending", 64'(rspExp.size()), 64'd0);
        repeat (4) @(posedge CLK);
        #1;
        check("ind_chan_drained", 64'(indTail[ch] - indHead[ch]), 64'd0);
    endtask

    initial begin
        int base;
        int t;
        RST                = 1'b1;
        bus.cmd_valid      = 1'b1;
        bus.cmd_data       = 32'h4000_0002;
        bus.indIntrChannel = 32'd0;
        rspRandom          = 1'b1;
        rspForce           = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_en_request", 64'(bus.EN_request), 64'd0);
        check("rst_en_indication", 64'(bus.EN_indication), 64'd0);
        check("rst_err", 64'(bus.err_badchan), 64'd0);
        check("rst_sel_req", 64'(bus.selectRequest), 64'd0);
        check("rst_sel_ind", 64'(bus.selectIndication), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_enq_data", 64'(bus.requestEnqV), 64'd0);
        @(posedge CLK);
        #1;
        RST           = 1'b0;
        bus.cmd_valid = 1'b0;

        // Directed request messages, then randomized ones.
        send_msg(2'd1, 2, 1'b1);
        send_msg(2'd3, 3, 1'b1);
        for (int i = 0; i < 20; i++)
            send_msg(2'($urandom_range(0, 3)), $urandom_range(0, 5), 1'b0);
        wait_req_done();

        // Directed indication drains, including a burst split across frames.
        ind_frame(1, 3, 1'b1);
        ind_frame(0, 10, 1'b0);

        // Both paths concurrently.
        fork
            begin
                for (int i = 0; i < 15; i++)
                    send_msg(2'($urandom_range(0, 3)), $urandom_range(1, 6), 1'b0);
            end
            begin
                for (int j = 0; j < 6; j++)
                    ind_frame($urandom_range(0, NUM_IND - 1), $urandom_range(1, 20), 1'b0);
            end
        join
        wait_req_done();

        // Bad request header and bad interrupt in the same cycle: one pulse.
        @(posedge CLK);
        #1;
        bus.indIntrChannel = 32'd3;
        expErr++;
        send_word(32'hC000_0001, 1'b1);
        bus.indIntrChannel = 32'd0;
        send_word($urandom, 1'b0);
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset in the middle of a frame after one data word.
        rspRandom = 1'b0;
        rspForce  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            indMem[1][indTail[1] % DEPTH] = 32'hA1 + 32'(i);
            indTail[1]++;
        end
        rspExp.push_back(32'h4000_0003);
        rspExp.push_back(32'h0000_00A1);
        base = rspHs;
        bus.indIntrChannel = 32'd2;
        t = 0;
        while (rspHs < base + 2 && t < 200) begin
            @(posedge CLK);
            t++;
        end
        check("rst_mid_frame_reach", 64'(rspHs - base), 64'd2);
        #1;
        rspForce           = 1'b0;
        bus.indIntrChannel = 32'd0;
        RST                = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("postrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("postrst_en_ind", 64'(bus.EN_indication), 64'd0);
        check("postrst_sel_ind", 64'(bus.selectIndication), 64'd0);
        check("postrst_rsp_pending", 64'(rspExp.size()), 64'd0);
        rspRandom = 1'b1;
        @(posedge CLK);
        #1;
        send_msg(2'd1, 2, 1'b1);
        wait_req_done();

        repeat (5) @(posedge CLK);
        check("final_req_left", 64'(reqExp.size()), 64'd0);
        check("final_rsp_left", 64'(rspExp.size()), 64'd0);
        check("err_pulses", 64'(errSeen), 64'(expErr));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
